// File: rtl/code_entry_fsm_pkg.sv
// ============================================================================
// Module   : code_entry_fsm_pkg
// Purpose  : State encoding, key indices and shared helpers for code_entry_fsm
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package code_entry_fsm_pkg;

   localparam int CODE_LEN    = 4;
   localparam int KEY_CONFIRM = 10;
   localparam int KEY_CLEAR   = 11;
   localparam int KEY_W       = 12;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ENTRY = 3'd1,
      CHECK = 3'd2,
      ERROR = 3'd3,
      LOCK  = 3'd4,
      FIRE  = 3'd5
   } state_t;

   // Failure counter stops at its top value instead of wrapping.
   function automatic logic [1:0] fail_sat_inc(input logic [1:0] v);
      return (v == 2'd3) ? v : v + 2'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/code_entry_fsm_hold_timer.sv
// ============================================================================
// Module   : hold_timer
// Purpose  : Loadable down-counter with a done flag for ERROR/LOCK holds
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hold_timer
   import code_entry_fsm_pkg::*;
#(
   parameter int WIDTH = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_en,
   output logic             o_done
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_en && (r_count != '0)) begin
         r_count <= r_count - WIDTH'(1);
      end
   end

   assign o_done = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/code_entry_fsm.sv
// ============================================================================
// Module   : code_entry_fsm
// Purpose  : Four-digit keypad code entry with error hold and optional lockout
//            (lockout enabled by defining CODE_ENTRY_LOCKOUT_EN)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module code_entry_fsm
   import code_entry_fsm_pkg::*;
#(
   parameter logic [15:0] PASSWORD    = 16'h1234,
   parameter int          MAX_FAIL    = 3,
   parameter logic [23:0] LOCK_CYCLES = 24'd125000,
   parameter logic [15:0] ERR_CYCLES  = 16'd2500
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [KEY_W-1:0] key_pulse,
   output logic [15:0]      entry_code,
   output logic [2:0]       digit_cnt,
   output logic             fire,
   output logic             err,
   output logic             locked,
   output logic [1:0]       fail_cnt
);

   localparam int c_TMR_W = $bits(LOCK_CYCLES);
   // Timer counts down to zero inclusive, so load N-1 for an N-cycle hold.
   localparam logic [c_TMR_W-1:0] c_ERR_LOAD  =
      (ERR_CYCLES == 16'd0) ? '0 : c_TMR_W'(ERR_CYCLES - 16'd1);
   localparam logic [c_TMR_W-1:0] c_LOCK_LOAD =
      (LOCK_CYCLES == 24'd0) ? '0 : (LOCK_CYCLES - 24'd1);

`ifdef CODE_ENTRY_LOCKOUT_EN
   localparam bit c_LOCKOUT_EN = 1'b1;
`else
   localparam bit c_LOCKOUT_EN = 1'b0;
`endif

   state_t               r_state;
   logic [15:0]          r_entry_code;
   logic [2:0]           r_digit_cnt;
   logic [1:0]           r_fail_cnt;
   logic                 r_fire;
   logic                 r_err;

   state_t               w_state_nxt;
   logic [15:0]          w_code_nxt;
   logic [2:0]           w_cnt_nxt;
   logic [1:0]           w_fail_nxt;
   logic [1:0]           w_fail_inc;
   logic                 w_lock_hit;
   logic                 w_tmr_load;
   logic [c_TMR_W-1:0]   w_tmr_val;
   logic                 w_tmr_en;
   logic                 w_tmr_done;

   logic                 w_key_multi;
   logic                 w_key_one;
   logic                 w_digit_vld;
   logic                 w_confirm;
   logic                 w_clear;
   logic [3:0]           w_digit;

   // A cycle with several keys is dropped: none of the decoded strobes fire.
   assign w_key_multi = |(key_pulse & (key_pulse - 12'd1));
   assign w_key_one   = (|key_pulse) && !w_key_multi;
   assign w_digit_vld = w_key_one && (|key_pulse[9:0]);
   assign w_confirm   = w_key_one && key_pulse[KEY_CONFIRM];
   assign w_clear     = w_key_one && key_pulse[KEY_CLEAR];

   always_comb begin
      w_digit = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (key_pulse[i]) begin
            w_digit = 4'(i);
         end
      end
   end

   assign w_fail_inc = fail_sat_inc(r_fail_cnt);
   assign w_lock_hit = c_LOCKOUT_EN && (int'(w_fail_inc) == MAX_FAIL);
   assign w_tmr_en   = (r_state == ERROR) || (r_state == LOCK);

   always_comb begin
      w_state_nxt = r_state;
      w_code_nxt  = r_entry_code;
      w_cnt_nxt   = r_digit_cnt;
      w_fail_nxt  = r_fail_cnt;
      w_tmr_load  = 1'b0;
      w_tmr_val   = c_ERR_LOAD;

      case (r_state)
         IDLE, ENTRY: begin
            if (w_clear) begin
               w_code_nxt  = '0;
               w_cnt_nxt   = '0;
               w_state_nxt = IDLE;
            end else if (w_digit_vld) begin
               if (r_digit_cnt < 3'(CODE_LEN)) begin
                  w_code_nxt  = {r_entry_code[11:0], w_digit};
                  w_cnt_nxt   = r_digit_cnt + 3'd1;
                  w_state_nxt = ENTRY;
               end
            end else if (w_confirm && (r_state == ENTRY)) begin
               w_state_nxt = CHECK;
            end
         end

         CHECK: begin
            if ((r_digit_cnt == 3'(CODE_LEN)) && (r_entry_code == PASSWORD)) begin
               w_fail_nxt  = '0;
               w_state_nxt = FIRE;
            end else begin
               w_fail_nxt = w_fail_inc;
               w_tmr_load = 1'b1;
               if (w_lock_hit) begin
                  w_tmr_val   = c_LOCK_LOAD;
                  w_state_nxt = LOCK;
               end else begin
                  w_state_nxt = ERROR;
               end
            end
         end

         ERROR: begin
            if (w_tmr_done) begin
               w_code_nxt  = '0;
               w_cnt_nxt   = '0;
               w_state_nxt = IDLE;
            end
         end

`ifdef CODE_ENTRY_LOCKOUT_EN
         LOCK: begin
            if (w_tmr_done) begin
               w_code_nxt  = '0;
               w_cnt_nxt   = '0;
               w_fail_nxt  = '0;
               w_state_nxt = IDLE;
            end
         end
`endif

         FIRE: begin
            w_state_nxt = FIRE;
         end

         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_entry_code <= '0;
         r_digit_cnt  <= '0;
         r_fail_cnt   <= '0;
         r_fire       <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_entry_code <= w_code_nxt;
         r_digit_cnt  <= w_cnt_nxt;
         r_fail_cnt   <= w_fail_nxt;
         r_fire       <= (w_state_nxt == FIRE);
         r_err        <= (w_state_nxt == ERROR);
      end
   end

`ifdef CODE_ENTRY_LOCKOUT_EN
   logic r_locked;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_locked <= 1'b0;
      end else begin
         r_locked <= (w_state_nxt == LOCK);
      end
   end

   assign locked = r_locked;
`else
   assign locked = 1'b0;
`endif

   hold_timer #(
      .WIDTH      (c_TMR_W)
   ) u_hold_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_tmr_load),
      .i_load_val (w_tmr_val),
      .i_en       (w_tmr_en),
      .o_done     (w_tmr_done)
   );

   assign entry_code = r_entry_code;
   assign digit_cnt  = r_digit_cnt;
   assign fail_cnt   = r_fail_cnt;
   assign fire       = r_fire;
   assign err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_code_entry_fsm.sv
// ============================================================================
// Module   : tb_code_entry_fsm
// Purpose  : Directed self-checking bench for code_entry_fsm
//            (lockout scenarios selected by CODE_ENTRY_LOCKOUT_EN)
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_code_entry_fsm;
   import code_entry_fsm_pkg::*;

   localparam int c_ERR  = 20;
   localparam int c_LOCK = 40;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [11:0] key_pulse = '0;
   logic [15:0] entry_code;
   logic [2:0]  digit_cnt;
   logic        fire;
   logic        err;
   logic        locked;
   logic [1:0]  fail_cnt;

   int checks = 0;
   int errors = 0;
   int n;

   always #5 clk = ~clk;

   code_entry_fsm #(
      .PASSWORD    (16'h1234),
      .MAX_FAIL    (3),
      .LOCK_CYCLES (24'(c_LOCK)),
      .ERR_CYCLES  (16'(c_ERR))
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_pulse  (key_pulse),
      .entry_code (entry_code),
      .digit_cnt  (digit_cnt),
      .fire       (fire),
      .err        (err),
      .locked     (locked),
      .fail_cnt   (fail_cnt)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic press_raw(input logic [11:0] v);
      @(negedge clk);
      key_pulse = v;
      @(negedge clk);
      key_pulse = '0;
   endtask

   task automatic press(input int idx);
      press_raw(12'd1 << idx);
   endtask

   // Counts negedges on which err (sel=0) or locked (sel=1) is high, holding a key meanwhile.
   task automatic count_hold(input bit sel, input logic [11:0] held, output int cnt);
      cnt = 0;
      key_pulse = held;
      while (((sel ? locked : err) === 1'b1) && (cnt < 1000)) begin
         cnt++;
         @(negedge clk);
      end
      key_pulse = '0;
   endtask

   task automatic wrong_attempt();
      press(9);
      press(KEY_CONFIRM);
      @(negedge clk);
   endtask

   task automatic async_reset_check(input string tag);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check({tag, "_code"},   entry_code,         16'h0000);
      check({tag, "_cnt"},    16'(digit_cnt),     16'd0);
      check({tag, "_fail"},   16'(fail_cnt),      16'd0);
      check({tag, "_fire"},   16'(fire),          16'd0);
      check({tag, "_err"},    16'(err),           16'd0);
      check({tag, "_locked"}, 16'(locked),        16'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_code",   entry_code,     16'h0000);
      check("rst_cnt",    16'(digit_cnt), 16'd0);
      check("rst_fail",   16'(fail_cnt),  16'd0);
      check("rst_fire",   16'(fire),      16'd0);
      check("rst_err",    16'(err),       16'd0);
      check("rst_locked", 16'(locked),    16'd0);
      rst_n = 1'b1;

      // Correct code: fire two cycles after confirm, then terminal
      press(1); press(2); press(3); press(4);
      check("ok_code", entry_code, 16'h1234);
      check("ok_cnt",  16'(digit_cnt), 16'd4);
      press(KEY_CONFIRM);
      check("ok_fire_in_check", 16'(fire), 16'd0);
      @(negedge clk);
      check("ok_fire", 16'(fire), 16'd1);
      check("ok_fail", 16'(fail_cnt), 16'd0);
      press(5); press(KEY_CLEAR);
      check("fire_terminal", 16'(fire), 16'd1);
      check("fire_code_held", entry_code, 16'h1234);
      async_reset_check("rst_in_fire");

      // Wrong code: err for c_ERR cycles, keys ignored meanwhile
      press(1); press(2); press(3); press(5);
      press(KEY_CONFIRM);
      @(negedge clk);
      check("bad_err", 16'(err), 16'd1);
      check("bad_fail", 16'(fail_cnt), 16'd1);
      count_hold(1'b0, 12'd1 << 7, n);
      check("bad_err_len", 16'(n), 16'(c_ERR));
      check("bad_cnt_after", 16'(digit_cnt), 16'd0);
      check("bad_code_after", entry_code, 16'h0000);
      check("bad_fail_after", 16'(fail_cnt), 16'd1);

      // Confirm in IDLE is ignored
      press(KEY_CONFIRM);
      @(negedge clk);
      check("idle_confirm_err", 16'(err), 16'd0);

      // Two keys at once are ignored; short code is a mismatch
      press(1); press(2);
      press_raw(12'h003);
      check("multi_cnt", 16'(digit_cnt), 16'd2);
      check("multi_code", entry_code, 16'h0012);
      press(KEY_CONFIRM);
      @(negedge clk);
      check("short_err", 16'(err), 16'd1);
      check("short_fail", 16'(fail_cnt), 16'd2);
      count_hold(1'b0, 12'h000, n);
      check("short_err_len", 16'(n), 16'(c_ERR));

      // Clear keeps fail_cnt; fifth digit ignored; match zeroes fail_cnt
      press(1); press(2); press(KEY_CLEAR);
      check("clr_cnt", 16'(digit_cnt), 16'd0);
      check("clr_code", entry_code, 16'h0000);
      check("clr_fail", 16'(fail_cnt), 16'd2);
      press(1); press(2); press(3); press(4); press(9);
      check("five_code", entry_code, 16'h1234);
      check("five_cnt", 16'(digit_cnt), 16'd4);
      press(KEY_CONFIRM);
      @(negedge clk);
      check("five_fire", 16'(fire), 16'd1);
      check("five_fail", 16'(fail_cnt), 16'd0);
      async_reset_check("rst_in_fire2");

      // Repeated failures
      wrong_attempt();
      count_hold(1'b0, 12'h000, n);
      wrong_attempt();
      count_hold(1'b0, 12'h000, n);
      check("rep_fail2", 16'(fail_cnt), 16'd2);
      wrong_attempt();
`ifdef CODE_ENTRY_LOCKOUT_EN
      check("lock_locked", 16'(locked), 16'd1);
      check("lock_err", 16'(err), 16'd0);
      check("lock_fail", 16'(fail_cnt), 16'd3);
      count_hold(1'b1, 12'd1 << 5, n);
      check("lock_len", 16'(n), 16'(c_LOCK));
      check("lock_cnt_after", 16'(digit_cnt), 16'd0);
      check("lock_fail_after", 16'(fail_cnt), 16'd0);
      check("lock_locked_after", 16'(locked), 16'd0);
      wrong_attempt();
      count_hold(1'b0, 12'h000, n);
      wrong_attempt();
      count_hold(1'b0, 12'h000, n);
      wrong_attempt();
      check("lock2_locked", 16'(locked), 16'd1);
      async_reset_check("rst_in_lock");
`else
      check("nolock_err", 16'(err), 16'd1);
      check("nolock_locked", 16'(locked), 16'd0);
      check("nolock_fail", 16'(fail_cnt), 16'd3);
      count_hold(1'b0, 12'h000, n);
      check("nolock_err_len", 16'(n), 16'(c_ERR));
      wrong_attempt();
      check("sat_err", 16'(err), 16'd1);
      check("sat_fail", 16'(fail_cnt), 16'd3);
      async_reset_check("rst_in_error");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
